reg_readout8: RTL and testbench

REG_READOUT8 -- requirements
Module: reg_readout8

---
 rtl/reg_readout8_pkg.sv | 15 +
 rtl/reg_readout8_settle_counter.sv | 37 +++
 rtl/reg_readout8.sv | 107 ++++++++++
 tb/tb_reg_readout8.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_readout8_pkg.sv
// Shared types and constants for the reg_readout8 serialised register readout block.
package reg_readout8_pkg;

  localparam int unsigned DATA_W = 8;
  // Settle counter width; covers DELAYTIME 0..15.
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    VALID = 2'd2
  } state_e;

endpackage

// File: rtl/reg_readout8_settle_counter.sv
// Settle counter: synchronous clear has priority over enable; tc_o flags cnt == Limit.
module settle_counter
  import reg_readout8_pkg::*;
#(
  parameter logic [CNT_W-1:0] Limit = '0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == Limit);

endmodule

// File: rtl/reg_readout8.sv
// reg_readout8: captures a register byte on EO and drives it onto a bus one bit at a time,
// LSB first, with DELAYTIME settle cycles before each bit. Holds the byte with bus_valid
// until bus_ready. Optional parity output when READOUT_PARITY_EN is defined.
module reg_readout8
  import reg_readout8_pkg::*;
#(
  parameter int unsigned DELAYTIME = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              EO,
  input  logic              bus_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              bus_valid,
  output logic              busy
`ifdef READOUT_PARITY_EN
  ,
  output logic              parity_out
`endif
);

  localparam logic [CNT_W-1:0] SettleLimit = CNT_W'(DELAYTIME);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              cnt_clr, cnt_en, cnt_tc;

  settle_counter #(
    .Limit(SettleLimit)
  ) u_settle (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  // Next-state and datapath: capture in IDLE, one bit per settle period in SHIFT.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bus_out_d = bus_out_q;
    idx_d     = idx_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (EO) begin
          shadow_d  = reg_data;
          bus_out_d = '0;
          idx_d     = '0;
          cnt_clr   = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          bus_out_d[idx_q] = shadow_q[idx_q];
          cnt_clr          = 1'b1;
          idx_d            = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = VALID;
          end
        end
      end
      VALID: begin
        // EO is deliberately not looked at here, even on the releasing edge.
        if (bus_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      bus_out_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      bus_out_q <= bus_out_d;
      idx_q     <= idx_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign busy      = (state_q != IDLE);
  assign bus_oe    = busy;
  assign bus_valid = (state_q == VALID);

`ifdef READOUT_PARITY_EN
  assign parity_out = bus_valid & (^shadow_q);
`endif

endmodule

// File: tb/tb_reg_readout8.sv
// Bench for reg_readout8: two instances (DELAYTIME 5 and 0) share stimulus; a cycle-count
// reference model predicts every output each cycle, plus directed scenario checks.
module tb_reg_readout8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] reg_data;
  logic       eo;
  logic       bus_ready;

  logic [7:0] out5, out0;
  logic       oe5, oe0, val5, val0, busy5, busy0;
`ifdef READOUT_PARITY_EN
  logic       par5, par0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_readout8 #(.DELAYTIME(5)) u_d5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg_data (reg_data),
    .EO       (eo),
    .bus_ready(bus_ready),
    .bus_out  (out5),
    .bus_oe   (oe5),
    .bus_valid(val5),
    .busy     (busy5)
`ifdef READOUT_PARITY_EN
    ,
    .parity_out(par5)
`endif
  );

  reg_readout8 #(.DELAYTIME(0)) u_d0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg_data (reg_data),
    .EO       (eo),
    .bus_ready(bus_ready),
    .bus_out  (out0),
    .bus_oe   (oe0),
    .bus_valid(val0),
    .busy     (busy0)
`ifdef READOUT_PARITY_EN
    ,
    .parity_out(par0)
`endif
  );

  // Reference model: per instance, captured byte and cycles elapsed since capture.
  int         dly[2] = '{5, 0};
  bit         m_busy[2];
  int         m_cyc[2];
  logic [7:0] m_byte[2];
  logic [7:0] m_last[2];

  function automatic bit m_valid(int i);
    return m_busy[i] && (m_cyc[i] >= 8 * (dly[i] + 1));
  endfunction

  // Expected {bus_out, bus_valid, bus_oe, busy}.
  function automatic logic [10:0] exp_vec(int i);
    int         nb;
    logic [7:0] o;
    if (!m_busy[i]) return {m_last[i], 3'b000};
    nb = m_cyc[i] / (dly[i] + 1);
    if (nb > 8) nb = 8;
    o = m_byte[i] & 8'((1 << nb) - 1);
    return {o, m_valid(i), 1'b1, 1'b1};
  endfunction

  function automatic logic [10:0] obs_vec(int i);
    if (i == 0) return {out5, val5, oe5, busy5};
    return {out0, val0, oe0, busy0};
  endfunction

  function automatic logic exp_par(int i);
    return m_valid(i) ? ^m_byte[i] : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_cyc[i]  = 0;
      m_byte[i] = 8'h00;
      m_last[i] = 8'h00;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!m_busy[i]) begin
        if (eo) begin
          m_busy[i] = 1'b1;
          m_byte[i] = reg_data;
          m_cyc[i]  = 0;
        end
      end else if (m_valid(i)) begin
        if (bus_ready) begin
          m_busy[i] = 1'b0;
          m_last[i] = m_byte[i];
        end
      end else begin
        m_cyc[i]++;
      end
    end
  endtask

  task automatic check_all();
    check("d5_outputs", obs_vec(0), exp_vec(0));
    check("d0_outputs", obs_vec(1), exp_vec(1));
`ifdef READOUT_PARITY_EN
    check("d5_parity", 11'(par5), 11'(exp_par(0)));
    check("d0_parity", 11'(par0), 11'(exp_par(1)));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_valid5();
    int n = 0;
    while (!val5 && n < 100) begin
      step();
      n++;
    end
    check("wait_valid_timeout", 11'(val5), 11'(1));
  endtask

  task automatic run_until_idle();
    eo        = 1'b0;
    bus_ready = 1'b0;
    wait_valid5();
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] tbl[8];
    int         n;
    tbl = '{8'h00, 8'h00, 8'h04, 8'h0C, 8'h1C, 8'h3C, 8'h3C, 8'h3C};

    rst_n     = 1'b0;
    reg_data  = 8'h00;
    eo        = 1'b0;
    bus_ready = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Default DELAYTIME: 0xA5 with bus_ready already high, 48-cycle latency.
    reg_data  = 8'hA5;
    eo        = 1'b1;
    bus_ready = 1'b1;
    step();
    eo = 1'b0;
    n  = 0;
    while (!val5 && n < 60) begin
      step();
      n++;
    end
    check("latency48", 11'(n), 11'(48));
    check("a5_value", {3'b000, out5}, {3'b000, 8'hA5});
    step();
    check("a5_back_idle", 11'(busy5), 11'(0));
    bus_ready = 1'b0;

    // DELAYTIME=0 stepping pattern for 0x3C.
    reg_data = 8'h3C;
    eo       = 1'b1;
    step();
    eo = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("d0_step%0d", k), {3'b000, out0}, {3'b000, tbl[k]});
    end
    repeat (3) step();
    check("d0_hold_valid", {out0, val0, 2'b00}, {8'h3C, 1'b1, 2'b00});
    run_until_idle();

    // Source changes after capture and EO while busy are ignored.
    reg_data = 8'h81;
    eo       = 1'b1;
    step();
    eo       = 1'b0;
    reg_data = 8'hFF;
    for (int k = 0; k < 60; k++) begin
      eo = (k == 10 || k == 25);
      step();
    end
    eo = 1'b0;
    check("x81_value", {3'b000, out5}, {3'b000, 8'h81});
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    step();
    check("x81_no_second", 11'(busy5), 11'(0));

    // Reset mid-transfer after bit 3, then a clean transfer.
    reg_data = 8'h5A;
    eo       = 1'b1;
    step();
    eo = 1'b0;
    repeat (24) step();
    check("x5a_partial", {3'b000, out5}, {3'b000, 8'h0A});
    do_reset();
    reg_data = 8'h12;
    eo       = 1'b1;
    step();
    run_until_idle();
    check("x12_value", {3'b000, out5}, {3'b000, 8'h12});

    // EO coincident with the releasing bus_ready edge is ignored; held EO then starts.
    reg_data = 8'hC3;
    eo       = 1'b1;
    step();
    eo = 1'b0;
    wait_valid5();
    eo        = 1'b1;
    bus_ready = 1'b1;
    step();
    check("eo_ignored_release", 11'(busy5), 11'(0));
    bus_ready = 1'b0;
    step();
    check("eo_next_cycle", 11'(busy5), 11'(1));
    run_until_idle();

`ifdef READOUT_PARITY_EN
    reg_data = 8'h07;
    eo       = 1'b1;
    step();
    eo = 1'b0;
    repeat (8) step();
    check("parity_07", {val0, par0, 9'd0}, {1'b1, 1'b1, 9'd0});
    run_until_idle();
    reg_data = 8'h03;
    eo       = 1'b1;
    step();
    eo = 1'b0;
    repeat (8) step();
    check("parity_03", {val0, par0, 9'd0}, {1'b1, 1'b0, 9'd0});
    run_until_idle();
`endif

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      reg_data  = 8'($urandom);
      eo        = ($urandom_range(0, 3) == 0);
      bus_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
